// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: iteration scheduler for the LDPC decoder core.
// Runs one intrinsic VNU pass, then CNU/VNU rounds each followed by a
// one-cycle syndrome check. Terminates on zero syndrome, iteration limit,
// or a per-phase watchdog. All array enables are decoded from the
// registered state, so outputs are glitch-free Moore outputs.
module ldpc_iter_ctrl #(
    parameter int unsigned MAX_ITER    = 10,
    parameter int unsigned ITER_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_vnu_en,
    output logic              o_vnu_first,
    input  logic              i_vnu_over,
    output logic              o_cnu_en,
    input  logic              i_cnu_over,
    input  logic              i_syndrome_ok,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_success,
    output logic              o_timeout_err,
    output logic [ITER_W-1:0] o_iter_count
);

    localparam int unsigned        CNT_W      = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ITER_W-1:0]  ITER_LIMIT = ITER_W'(MAX_ITER);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INIT_VNU = 3'd1;
    localparam logic [2:0] S_CNU      = 3'd2;
    localparam logic [2:0] S_VNU      = 3'd3;
    localparam logic [2:0] S_CHECK    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_phase_cnt;
    logic [ITER_W-1:0] r_iter;
    logic              r_success;
    logic              r_timeout;

    logic              w_in_phase;
    logic              w_over_raw;
    logic              w_over_q;
    logic              w_wd_expire;
    logic [2:0]        w_next_phase;

    // Select the completion input of the active phase, qualify it, and detect watchdog expiry
    always_comb begin
        w_in_phase   = 1'b0;
        w_over_raw   = 1'b0;
        w_next_phase = S_IDLE;
        case (r_state)
            S_INIT_VNU: begin
                w_in_phase   = 1'b1;
                w_over_raw   = i_vnu_over;
                w_next_phase = S_CNU;
            end
            S_CNU: begin
                w_in_phase   = 1'b1;
                w_over_raw   = i_cnu_over;
                w_next_phase = S_VNU;
            end
            S_VNU: begin
                w_in_phase   = 1'b1;
                w_over_raw   = i_vnu_over;
                w_next_phase = S_CHECK;
            end
            default: ;
        endcase
        // A completion level left over from the previous phase is ignored on the first cycle.
        w_over_q    = w_in_phase && w_over_raw && (r_phase_cnt != '0);
        w_wd_expire = w_in_phase && !w_over_q && (r_phase_cnt == CNT_LAST);
    end

    // State, phase counter, iteration count and status registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_phase_cnt <= '0;
            r_iter      <= '0;
            r_success   <= 1'b0;
            r_timeout   <= 1'b0;
        end else if (i_abort) begin
            r_state     <= S_IDLE;
            r_phase_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_INIT_VNU;
                        r_phase_cnt <= '0;
                        r_iter      <= '0;
                        r_success   <= 1'b0;
                        r_timeout   <= 1'b0;
                    end
                end
                S_INIT_VNU, S_CNU, S_VNU: begin
                    if (w_over_q) begin
                        r_state     <= w_next_phase;
                        r_phase_cnt <= '0;
                        if (r_state == S_VNU) begin
                            r_iter <= r_iter + ITER_W'(1);
                        end
                    end else if (w_wd_expire) begin
                        r_state     <= S_DONE;
                        r_phase_cnt <= '0;
                        r_timeout   <= 1'b1;
                        r_success   <= 1'b0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    r_phase_cnt <= '0;
                    if (i_syndrome_ok) begin
                        r_state   <= S_DONE;
                        r_success <= 1'b1;
                    end else if (r_iter == ITER_LIMIT) begin
                        r_state   <= S_DONE;
                        r_success <= 1'b0;
                    end else begin
                        r_state   <= S_CNU;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_phase_cnt <= '0;
                end
            endcase
        end
    end

    assign o_vnu_en      = (r_state == S_INIT_VNU) || (r_state == S_VNU);
    assign o_vnu_first   = (r_state == S_INIT_VNU);
    assign o_cnu_en      = (r_state == S_CNU);
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_success     = r_success;
    assign o_timeout_err = r_timeout;
    assign o_iter_count  = r_iter;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Testbench for ldpc_iter_ctrl: per-cycle input schedules are generated up
// front, a phase-walk reference model predicts each decode's outcome, and a
// monitor pops the prediction whenever the DUT pulses done.
module tb_ldpc_iter_ctrl;

    localparam int MAXI = 10;
    localparam int IW   = 4;
    localparam int TO   = 64;
    localparam int NS   = 2048;

    logic          clk = 1'b0;
    logic          rst, start, abort, vnu_over, cnu_over, syn;
    logic          vnu_en, vnu_first, cnu_en, busy, done, success, terr;
    logic [IW-1:0] iter;

    always #5 clk = ~clk;

    ldpc_iter_ctrl #(
        .MAX_ITER    (MAXI),
        .ITER_W      (IW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_abort       (abort),
        .o_vnu_en      (vnu_en),
        .o_vnu_first   (vnu_first),
        .i_vnu_over    (vnu_over),
        .o_cnu_en      (cnu_en),
        .i_cnu_over    (cnu_over),
        .i_syndrome_ok (syn),
        .o_busy        (busy),
        .o_done        (done),
        .o_success     (success),
        .o_timeout_err (terr),
        .o_iter_count  (iter)
    );

    typedef struct {
        int done_cyc;
        int succ;
        int terr;
        int iter;
        int n_first;
        int n_vnu;
        int n_cnu;
    } exp_t;

    exp_t sbq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Input schedules indexed by cycle number within a decode (cycle 1 = first cycle after start edge)
    bit s_vo [NS];
    bit s_co [NS];
    bit s_syn[NS];
    // Model outputs: phase per cycle (1 init,2 cnu,3 vnu,4 check,5 done) and rounds completed so far
    int ph [NS];
    int itd[NS];
    int m_done, m_succ, m_terr, m_iter, m_first, m_vnu, m_cnu;
    int held_iter;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit over_at(input int kind, input int t);
        return (kind == 2) ? s_co[t] : s_vo[t];
    endfunction

    // Walk the decode phase by phase: a phase ends at the first completion seen
    // at offset >=1, or after TO cycles if none arrives within offsets 1..TO-1.
    function automatic void run_model();
        int  s    = 1;
        int  kind = 1;
        int  it   = 0;
        int  e, last;
        bit  fin  = 0;
        m_first = 0; m_vnu = 0; m_cnu = 0; m_succ = 0; m_terr = 0; m_done = 0;
        for (int i = 0; i < NS; i++) begin
            ph[i]  = 0;
            itd[i] = 0;
        end
        while (!fin) begin
            e = -1;
            for (int k = 1; k < TO; k++) begin
                if (over_at(kind, s + k)) begin
                    e = s + k;
                    break;
                end
            end
            last = (e < 0) ? (s + TO - 1) : e;
            for (int t = s; t <= last; t++) begin
                ph[t]  = kind;
                itd[t] = it;
            end
            if (kind == 1) begin
                m_first += last - s + 1;
                m_vnu   += last - s + 1;
            end else if (kind == 2) begin
                m_cnu   += last - s + 1;
            end else begin
                m_vnu   += last - s + 1;
            end
            if (e < 0) begin
                m_terr = 1;
                m_done = last + 1;
                fin    = 1;
            end else if (kind == 3) begin
                it++;
                ph[e + 1]  = 4;
                itd[e + 1] = it;
                if (s_syn[e + 1]) begin
                    m_succ = 1;
                    m_done = e + 2;
                    fin    = 1;
                end else if (it == MAXI) begin
                    m_done = e + 2;
                    fin    = 1;
                end else begin
                    s    = e + 2;
                    kind = 2;
                end
            end else begin
                s    = e + 1;
                kind = (kind == 1) ? 2 : 3;
            end
        end
        ph[m_done]  = 5;
        itd[m_done] = it;
        m_iter      = it;
    endfunction

    // vprob/cprob/sprob are 1-in-N chances per cycle; vhold keeps vnu_over high,
    // cnever keeps cnu_over low, sprob==0 keeps syndrome_ok low.
    task automatic gen_sched(input bit vhold, input int vprob, input bit cnever,
                             input int cprob, input int sprob);
        for (int t = 0; t < NS; t++) begin
            s_vo[t]  = vhold  ? 1'b1 : ($urandom_range(vprob - 1) == 0);
            s_co[t]  = cnever ? 1'b0 : ($urandom_range(cprob - 1) == 0);
            s_syn[t] = (sprob == 0) ? 1'b0 : ($urandom_range(sprob - 1) == 0);
        end
    endtask

    // mode 0: full decode, 1: abort during a VNU phase, 2: reset during a CNU phase
    task automatic run_decode(input int mode, input bit rnd_start);
        int   c0;
        int   cut = 0;
        exp_t x;
        run_model();
        if (mode != 0) begin
            for (int t = 1; t < m_done && cut == 0; t++) begin
                if (ph[t] == ((mode == 1) ? 3 : 2) && itd[t] >= 1) cut = t;
            end
            if (cut == 0) begin
                for (int t = 1; t < m_done && cut == 0; t++) begin
                    if (ph[t] == ((mode == 1) ? 3 : 2)) cut = t;
                end
            end
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        c0    = cyc;
        chk("start_busy",      busy,      1);
        chk("start_vnu_en",    vnu_en,    1);
        chk("start_vnu_first", vnu_first, 1);
        chk("start_cnu_en",    cnu_en,    0);
        chk("start_iter_clr",  iter,      0);
        chk("start_succ_clr",  success,   0);
        chk("start_terr_clr",  terr,      0);
        if (cut == 0) begin
            x.done_cyc = c0 + m_done - 1;
            x.succ     = m_succ;
            x.terr     = m_terr;
            x.iter     = m_iter;
            x.n_first  = m_first;
            x.n_vnu    = m_vnu;
            x.n_cnu    = m_cnu;
            sbq.push_back(x);
        end
        for (int t = 1; t <= m_done; t++) begin
            vnu_over = s_vo[t];
            cnu_over = s_co[t];
            syn      = s_syn[t];
            start    = rnd_start && ($urandom_range(5) == 0);
            abort    = (mode == 1) && (t == cut);
            rst      = (mode == 2) && (t == cut);
            tick();
            if (cut != 0 && t == cut) begin
                abort = 1'b0;
                rst   = 1'b0;
                start = 1'b0;
                chk("cut_vnu_en",    vnu_en,    0);
                chk("cut_vnu_first", vnu_first, 0);
                chk("cut_cnu_en",    cnu_en,    0);
                chk("cut_busy",      busy,      0);
                chk("cut_done",      done,      0);
                chk("cut_success",   success,   0);
                chk("cut_terr",      terr,      0);
                chk("cut_iter",      iter,      (mode == 1) ? itd[t] : 0);
                held_iter = (mode == 1) ? itd[t] : 0;
                break;
            end
        end
        vnu_over = 1'b0;
        cnu_over = 1'b0;
        syn      = 1'b0;
        start    = 1'b0;
        if (cut == 0) begin
            repeat (3) tick();
            chk("hold_success", success, m_succ);
            chk("hold_terr",    terr,    m_terr);
            chk("hold_iter",    iter,    m_iter);
            chk("hold_busy",    busy,    0);
        end
    endtask

    // Monitor: per-cycle enable sanity, and scoreboard pop on every done pulse
    int   a_first, a_vnu, a_cnu;
    bit   done_prev = 0;
    exp_t y;
    initial begin
        a_first = 0; a_vnu = 0; a_cnu = 0;
        forever begin
            @(negedge clk);
            if (start && !busy && !abort) begin
                a_first = 0; a_vnu = 0; a_cnu = 0;
            end
            a_first += int'(vnu_first);
            a_vnu   += int'(vnu_en);
            a_cnu   += int'(cnu_en);
            if (busy) begin
                chk("en_overlap", int'(vnu_en && cnu_en), 0);
                chk("first_wo_vnu_en", int'(vnu_first && !vnu_en), 0);
            end
            if (done_prev) begin
                chk("done_one_cycle", done, 0);
                chk("idle_after_done", busy, 0);
            end
            done_prev = done;
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    y = sbq.pop_front();
                    chk("done_cycle",  cyc,     y.done_cyc);
                    chk("done_busy",   busy,    1);
                    chk("done_en",     int'(vnu_en || cnu_en), 0);
                    chk("success",     success, y.succ);
                    chk("timeout_err", terr,    y.terr);
                    chk("iter_count",  iter,    y.iter);
                    chk("first_cycles", a_first, y.n_first);
                    chk("vnu_cycles",  a_vnu,   y.n_vnu);
                    chk("cnu_cycles",  a_cnu,   y.n_cnu);
                end
            end
        end
    end

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        vnu_over = 1'b0; cnu_over = 1'b0; syn = 1'b0;
        held_iter = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_vnu_en",    vnu_en,    0);
        chk("rst_vnu_first", vnu_first, 0);
        chk("rst_cnu_en",    cnu_en,    0);
        chk("rst_busy",      busy,      0);
        chk("rst_done",      done,      0);
        chk("rst_success",   success,   0);
        chk("rst_terr",      terr,      0);
        chk("rst_iter",      iter,      0);

        // Minimum decode: immediate completions, first-round zero syndrome
        gen_sched(1'b1, 1, 1'b0, 1, 1);
        run_decode(0, 1'b0);
        // Syndrome never clears: run to the iteration limit
        gen_sched(1'b1, 1, 1'b0, 1, 0);
        run_decode(0, 1'b0);
        // vnu_over held high, cnu_over pulsed
        gen_sched(1'b1, 1, 1'b0, 3, 4);
        run_decode(0, 1'b0);
        // cnu_over never arrives: CNU watchdog
        gen_sched(1'b1, 1, 1'b1, 1, 1);
        run_decode(0, 1'b0);
        // Reset during a CNU phase
        gen_sched(1'b1, 1, 1'b0, 1, 0);
        run_decode(2, 1'b0);
        // Abort during a VNU phase, then start with abort, then a clean start
        gen_sched(1'b1, 1, 1'b0, 2, 0);
        run_decode(1, 1'b0);
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", busy,   0);
        chk("abort_start_en",   int'(vnu_en || cnu_en), 0);
        chk("abort_start_iter", iter,   held_iter);
        tick();
        chk("abort_start_idle", busy,   0);
        gen_sched(1'b0, 2, 1'b0, 2, 3);
        run_decode(0, 1'b0);

        // Randomized decodes, with stray start requests while busy
        for (int n = 0; n < 30; n++) begin
            int vp, cp, sp;
            bit vh, cn;
            vh = ($urandom_range(3) == 0);
            cn = ($urandom_range(9) == 0);
            case ($urandom_range(3))
                0: vp = 1;
                1: vp = 2;
                2: vp = 4;
                default: vp = 20;
            endcase
            case ($urandom_range(3))
                0: cp = 1;
                1: cp = 2;
                2: cp = 5;
                default: cp = 20;
            endcase
            case ($urandom_range(3))
                0: sp = 0;
                1: sp = 8;
                2: sp = 3;
                default: sp = 1;
            endcase
            gen_sched(vh, vp, cn, cp, sp);
            run_decode(0, 1'b1);
        end

        repeat (4) tick();
        chk("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ldpc_iter_ctrl.md
# ldpc_iter_ctrl

Iteration scheduler for the LDPC decoder core. Sequences the variable-node (VNU) and check-node (CNU) processing phases of one codeword: a first VNU pass that broadcasts intrinsic LLRs, then alternating CNU/VNU rounds with a syndrome check after each round. It stops on a zero syndrome, on the iteration limit, or on a phase watchdog timeout. It sits between the frame-level input/output logic and the VNU/CNU arrays and owns all their enables.

## Interface
- MAX_ITER, 10: maximum CNU+VNU rounds after the intrinsic pass (1..2^ITER_W-1).
- ITER_W, 4: width of the iteration counter.
- TIMEOUT_CYC, 64: maximum cycles a phase may wait for its completion input (≥2).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to decode the loaded frame; honoured only in IDLE.
- abort  in  1  returns the block to IDLE from any state; no done pulse.
- vnu_en  out  1  VNU array enable.
- vnu_first  out  1  selects intrinsic pass-through mode in the VNUs; high only during the intrinsic pass.
- vnu_over  in  1  VNU phase complete (level).
- cnu_en  out  1  CNU array enable.
- cnu_over  in  1  CNU phase complete (level).
- syndrome_ok  in  1  all parity checks satisfied by the current hard decisions; valid in CHECK.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of a decode.
- success  out  1  decode ended on a zero syndrome; held until next accepted start.
- timeout_err  out  1  decode ended on watchdog; held until next accepted start.
- iter_count  out  ITER_W  completed CNU+VNU rounds; held until next accepted start.

## Operation
- States: IDLE, INIT_VNU, CNU, VNU, CHECK, DONE. Moore outputs, all decoded from registered state.
- IDLE: enables low. start=1 and abort=0 → INIT_VNU. On this transition, clear iter_count, success and timeout_err.
- INIT_VNU: vnu_en=1, vnu_first=1. Qualified vnu_over → CNU.
- CNU: cnu_en=1. Qualified cnu_over → VNU.
- VNU: vnu_en=1, vnu_first=0. Qualified vnu_over → CHECK, and iter_count increments.
- CHECK: samples syndrome_ok.
  - syndrome_ok=1 → DONE with success=1.
  - Otherwise, iter_count==MAX_ITER → DONE with success=0.
  - Otherwise → CNU.
- DONE: done=1 for one cycle → IDLE.
- Qualification: the completion units may hold over high from the previous phase. An over input is honoured only when the phase cycle counter is ≥1, so the first cycle of every phase ignores it.
- Watchdog: the phase cycle counter clears on entry to INIT_VNU, CNU and VNU, and increments each cycle in that state. If it reaches TIMEOUT_CYC-1 with over not qualified, the FSM → DONE with timeout_err=1 and success=0. If qualified over arrives in the same cycle, the normal transition wins.
- abort=1 in any state → IDLE next cycle. Enables drop, done stays low, and status outputs keep their current values. abort beats start in the same cycle.
- start outside IDLE is ignored.
- iter_count saturates logically at MAX_ITER and never wraps, because CHECK terminates the decode at the limit.

## Timing
- Reset values: state IDLE, vnu_en=0, vnu_first=0, cnu_en=0, busy=0, done=0, success=0, timeout_err=0, iter_count=0, phase counter 0.
- start sampled at edge N → busy, vnu_en and vnu_first high in cycle N+1.
- Qualified over sampled at edge M → the old enable is low and the next enable is high in cycle M+1. There is no overlap and no gap between phases.
- CHECK lasts exactly one cycle.
- DONE lasts exactly one cycle. busy is high during DONE and low the cycle after.
- Minimum decode with immediate over inputs and a first-round zero syndrome: INIT_VNU 2 + CNU 2 + VNU 2 + CHECK 1 + DONE 1 = 8 cycles from start to the end of the done pulse.
- Status outputs change only on an accepted start, in CHECK/DONE entry, or on the watchdog.

## Test plan
- Reset mid-decode (in CNU) → all outputs equal their reset values the next cycle, and the FSM is in IDLE.
- start with over inputs pulsing on the second cycle of each phase, syndrome_ok=1 in the first CHECK → done 8 cycles after start, success=1, iter_count=1, enables never overlap.
- syndrome_ok always 0, MAX_ITER=10 → exactly 10 CNU/VNU rounds, done with success=0 and iter_count=10, vnu_first high only in INIT_VNU.
- vnu_over held high continuously, cnu_over pulsed → each phase lasts ≥2 cycles, and the stale level never skips a phase.
- cnu_over never asserted, TIMEOUT_CYC=64 → the CNU phase lasts 64 cycles, then done with timeout_err=1, success=0, iter_count=0.
- abort in VNU, then start in IDLE together with abort, then start alone → no done pulse, second start ignored, third decode starts and clears the status outputs.
